// File: rtl/divn_pkg.sv
// Shared types and helpers for the divide-by-N generator.
package divn_pkg;

   // IDLE: stopped. RUN: dividing. PEND: dividing with a shadow load queued for the next wrap.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } divn_state_t;

   typedef enum logic {
      PULSE  = 1'b0,
      SQUARE = 1'b1
   } divn_mode_t;

   // ceil(n/2): length of the high phase in SQUARE mode (odd N gets the longer high phase)
   function automatic logic [16:0] ceil_half(input logic [16:0] n);
      return (n + 17'd1) >> 1;
   endfunction

endpackage

// File: rtl/divide_by_n_fsm.sv
// Programmable divide-by-N with PULSE / SQUARE output and wrap-aligned divisor reloads.
module divide_by_n_fsm
   import divn_pkg::*;
#(
   parameter int WIDTH       = 4,
   parameter int DEFAULT_DIV = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] div_in,
   input  logic             mode_in,
   output logic             ready,
   output logic             y,
   output logic             tick,
   output logic [WIDTH-1:0] count
);

   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
   localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DEFAULT_DIV);

   divn_state_t      state_q, state_d;
   divn_mode_t       mode_q, mode_d, smode_q, smode_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] div_q, div_d, sdiv_q, sdiv_d;

   logic [WIDTH-1:0] n_eff;
   logic             running;
   logic             wrap;
   logic             accept;
   logic             sq_high;

   // divisors 0 and 1 both mean divide-by-1
   assign n_eff   = (div_q == '0) ? ONE : div_q;
   assign running = (state_q != IDLE);
   assign wrap    = (cnt_q == n_eff - ONE);
   assign accept  = load && ready;
   assign sq_high = (17'(cnt_q) < ceil_half(17'(n_eff)));

   // state, counter, active divisor/mode and shadow registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= DIV_RST;
         mode_q  <= PULSE;
         sdiv_q  <= '0;
         smode_q <= PULSE;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         mode_q  <= mode_d;
         sdiv_q  <= sdiv_d;
         smode_q <= smode_d;
      end
   end

   // next-state: loads only take effect at a period boundary (wrap or stop) so no period is cut short
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      mode_d  = mode_q;
      sdiv_d  = sdiv_q;
      smode_d = smode_q;
      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               div_d  = div_in;
               mode_d = divn_mode_t'(mode_in);
            end
            if (en) state_d = RUN;
         end
         RUN: begin
            if (!en) begin
               state_d = IDLE;
               cnt_d   = '0;
               if (accept) begin
                  div_d  = div_in;
                  mode_d = divn_mode_t'(mode_in);
               end
            end else begin
               cnt_d = wrap ? '0 : cnt_q + ONE;
               if (accept) begin
                  if (wrap) begin
                     // load on the wrap cycle: the new period starts right now
                     div_d  = div_in;
                     mode_d = divn_mode_t'(mode_in);
                  end else begin
                     sdiv_d  = div_in;
                     smode_d = divn_mode_t'(mode_in);
                     state_d = PEND;
                  end
               end
            end
         end
         PEND: begin
            if (!en) begin
               state_d = IDLE;
               cnt_d   = '0;
               div_d   = sdiv_q;
               mode_d  = smode_q;
            end else begin
               cnt_d = wrap ? '0 : cnt_q + ONE;
               if (wrap) begin
                  div_d   = sdiv_q;
                  mode_d  = smode_q;
                  state_d = RUN;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // outputs are decoded from registered state only
   always_comb begin
      ready = (state_q != PEND);
      tick  = running && (cnt_q == '0);
      y     = (mode_q == PULSE) ? tick : (running && sq_high);
      count = cnt_q;
   end

endmodule

// File: tb/tb_divide_by_n_fsm.sv
// Scoreboard bench for divide_by_n_fsm: each step queues the expected {ready,tick,y,count}.
module tb_divide_by_n_fsm;

   logic       clk;
   logic       reset;
   logic       en;
   logic       load;
   logic [3:0] div_in;
   logic       mode_in;
   logic       ready;
   logic       y;
   logic       tick;
   logic [3:0] count;

   logic [6:0] sb[$];
   int         ncmp = 0;
   int         nbad = 0;

   divide_by_n_fsm #(.WIDTH(4), .DEFAULT_DIV(3)) dut (
      .clk     (clk),
      .reset   (reset),
      .en      (en),
      .load    (load),
      .div_in  (div_in),
      .mode_in (mode_in),
      .ready   (ready),
      .y       (y),
      .tick    (tick),
      .count   (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // vector: inputs {en,load,mode,div} and expected post-edge {ready,tick,y,count}
   function automatic logic [13:0] v(input int e, input int l, input int m, input int d,
                                     input int r, input int t, input int yy, input int c);
      return {e[0], l[0], m[0], d[3:0], r[0], t[0], yy[0], c[3:0]};
   endfunction

   // drive one cycle of inputs, queue its expectation, land 1 time unit after the edge
   task automatic step(input logic [13:0] tv);
      en      = tv[13];
      load    = tv[12];
      mode_in = tv[11];
      div_in  = tv[10:7];
      sb.push_back(tv[6:0]);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      logic [13:0] tv[$];
      logic [6:0]  got, want;
      reset = 1'b0; en = 1'b1; load = 1'b0; div_in = '0; mode_in = 1'b0;
      sb.push_back(7'b100_0000);
      #1;
      got = {ready, tick, y, count}; want = sb.pop_front(); ncmp++;
      if (got !== want) begin
         nbad++; $display("FAIL reset_async got=%b want=%b", got, want);
      end
      step(v(1,0,0,0, 1,0,0,0));
      got = {ready, tick, y, count}; want = sb.pop_front(); ncmp++;
      if (got !== want) begin
         nbad++; $display("FAIL reset_held got=%b want=%b", got, want);
      end
      reset = 1'b1;
      tv = {v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,0,0,1), v(1,0,0,0, 1,0,0,2),
            v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,0,0,1), v(1,0,0,0, 1,0,0,2),
            v(0,0,0,0, 1,0,0,0)};
      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i]);
         got = {ready, tick, y, count}; want = sb.pop_front(); ncmp++;
         if (got !== want) begin
            nbad++; $display("FAIL default_div3 step %0d got=%b want=%b", i, got, want);
         end
      end
   endtask

   task automatic test_square;
      logic [13:0] tv[$];
      logic [6:0]  got, want;
      tv = {v(0,1,1,4, 1,0,0,0),
            v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,0,1,1), v(1,0,0,0, 1,0,0,2), v(1,0,0,0, 1,0,0,3),
            v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,0,1,1), v(1,0,0,0, 1,0,0,2), v(1,0,0,0, 1,0,0,3),
            v(0,0,0,0, 1,0,0,0)};
      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i]);
         got = {ready, tick, y, count}; want = sb.pop_front(); ncmp++;
         if (got !== want) begin
            nbad++; $display("FAIL square_n4 step %0d got=%b want=%b", i, got, want);
         end
      end
   endtask

   task automatic test_pend;
      logic [13:0] tv[$];
      logic [6:0]  got, want;
      // N=5 running, load N=2 at count=1; a load during PEND must be ignored
      tv = {v(0,1,0,5, 1,0,0,0),
            v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,0,0,1),
            v(1,1,0,2, 0,0,0,2), v(1,1,1,9, 0,0,0,3), v(1,0,0,0, 0,0,0,4),
            v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,0,0,1), v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,0,0,1),
            v(0,0,0,0, 1,0,0,0)};
      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i]);
         got = {ready, tick, y, count}; want = sb.pop_front(); ncmp++;
         if (got !== want) begin
            nbad++; $display("FAIL pend_reload step %0d got=%b want=%b", i, got, want);
         end
      end
   endtask

   task automatic test_wrap_load;
      logic [13:0] tv[$];
      logic [6:0]  got, want;
      tv = {v(0,1,0,3, 1,0,0,0),
            v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,0,0,1), v(1,0,0,0, 1,0,0,2),
            v(1,1,1,4, 1,1,1,0), v(1,0,0,0, 1,0,1,1), v(1,0,0,0, 1,0,0,2),
            v(1,1,0,2, 0,0,0,3), v(1,1,1,1, 1,1,1,0),
            v(1,0,0,0, 1,0,0,1), v(1,0,0,0, 1,1,1,0),
            v(0,0,0,0, 1,0,0,0)};
      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i]);
         got = {ready, tick, y, count}; want = sb.pop_front(); ncmp++;
         if (got !== want) begin
            nbad++; $display("FAIL wrap_load step %0d got=%b want=%b", i, got, want);
         end
      end
   endtask

   task automatic test_div01;
      logic [13:0] tv[$];
      logic [6:0]  got, want;
      tv = {v(0,1,0,0, 1,0,0,0),
            v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,1,1,0),
            v(1,1,1,1, 1,1,1,0), v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,1,1,0),
            v(1,1,1,0, 1,1,1,0), v(1,0,0,0, 1,1,1,0),
            v(0,0,0,0, 1,0,0,0)};
      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i]);
         got = {ready, tick, y, count}; want = sb.pop_front(); ncmp++;
         if (got !== want) begin
            nbad++; $display("FAIL div_0_1 step %0d got=%b want=%b", i, got, want);
         end
      end
   endtask

   task automatic test_pend_stop;
      logic [13:0] tv[$];
      logic [6:0]  got, want;
      // stopping while PEND applies the shadow (N=2 SQUARE) on IDLE entry
      tv = {v(0,1,0,4, 1,0,0,0),
            v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,0,0,1),
            v(1,1,1,2, 0,0,0,2), v(0,0,0,0, 1,0,0,0),
            v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,0,0,1), v(1,0,0,0, 1,1,1,0),
            v(0,0,0,0, 1,0,0,0)};
      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i]);
         got = {ready, tick, y, count}; want = sb.pop_front(); ncmp++;
         if (got !== want) begin
            nbad++; $display("FAIL pend_stop step %0d got=%b want=%b", i, got, want);
         end
      end
   endtask

   task automatic test_reset_pend;
      logic [13:0] tv[$];
      logic [6:0]  got, want;
      tv = {v(0,1,1,5, 1,0,0,0),
            v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,0,1,1), v(1,1,0,2, 0,0,1,2)};
      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i]);
         got = {ready, tick, y, count}; want = sb.pop_front(); ncmp++;
         if (got !== want) begin
            nbad++; $display("FAIL reset_pend_setup step %0d got=%b want=%b", i, got, want);
         end
      end
      load = 1'b0;
      #3;
      reset = 1'b0;
      sb.push_back(7'b100_0000);
      #1;
      got = {ready, tick, y, count}; want = sb.pop_front(); ncmp++;
      if (got !== want) begin
         nbad++; $display("FAIL reset_midperiod got=%b want=%b", got, want);
      end
      step(v(1,0,0,0, 1,0,0,0));
      got = {ready, tick, y, count}; want = sb.pop_front(); ncmp++;
      if (got !== want) begin
         nbad++; $display("FAIL reset_pend_held got=%b want=%b", got, want);
      end
      reset = 1'b1;
      tv = {v(1,0,0,0, 1,1,1,0), v(1,0,0,0, 1,0,0,1), v(1,0,0,0, 1,0,0,2),
            v(1,0,0,0, 1,1,1,0), v(0,0,0,0, 1,0,0,0)};
      for (int i = 0; i < tv.size(); i++) begin
         step(tv[i]);
         got = {ready, tick, y, count}; want = sb.pop_front(); ncmp++;
         if (got !== want) begin
            nbad++; $display("FAIL reset_pend_after step %0d got=%b want=%b", i, got, want);
         end
      end
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; load = 1'b0; div_in = '0; mode_in = 1'b0;
      #2;
      test_reset();
      test_square();
      test_pend();
      test_wrap_load();
      test_div01();
      test_pend_stop();
      test_reset_pend();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
      $finish;
   end

endmodule

// File: doc/divide_by_n_fsm.md
DIVIDE_BY_N_FSM -- requirements
Module: divide_by_n_fsm

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning divisor/counter width (legal range 2..16).
REQ-002 SHALL have parameter DEFAULT_DIV, default 3, meaning divisor loaded at reset.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port en, input, 1, run enable.
REQ-007 SHALL have port load, input, 1, request to load a new divisor and mode.
REQ-008 SHALL have port div_in, input, WIDTH, new divisor N.
REQ-009 SHALL have port mode_in, input, 1, new mode: 0 = PULSE, 1 = SQUARE.
REQ-010 SHALL have port ready, output, 1, high when a load can be accepted.
REQ-011 SHALL have port y, output, 1, divided output.
REQ-012 SHALL have port tick, output, 1, one-cycle marker at each period start.
REQ-013 SHALL have port count, output, WIDTH, current phase counter.

Function
REQ-014 SHALL implement states IDLE, RUN and PEND (RUN with a shadow load waiting).
REQ-015 SHALL treat an effective divisor as max(div_q, 1), so that div_q values 0 and 1 both divide by 1.
REQ-016 SHALL transition IDLE->RUN on en=1, with count=0 in the first RUN cycle.
REQ-017 SHALL transition RUN/PEND->IDLE on en=0, clearing count to 0 on that edge.
REQ-018 SHALL, in RUN/PEND, increment count by 1 each cycle and wrap to 0 after count == N-1.
REQ-019 SHALL drive tick = (state != IDLE) && (count == 0).
REQ-020 SHALL drive y = tick in PULSE mode.
REQ-021 SHALL drive y = (state != IDLE) && (count < ceil(N/2)) in SQUARE mode; odd N gives the longer high phase.
REQ-022 SHALL drive y=0 and tick=0 in IDLE.
REQ-023 SHALL accept a load when load && ready.
REQ-024 SHALL apply an accepted load in IDLE on the next edge.
REQ-025 SHALL, on a load accepted in RUN off the wrap cycle, capture div_in/mode_in into a shadow register, move to PEND and drop ready.
REQ-026 SHALL, in PEND, apply the shadow at the wrap edge (count == N-1 -> 0), return to RUN and raise ready.
REQ-027 SHALL apply a load accepted on the wrap cycle itself directly at that wrap; ready stays 1 and no PEND is entered.
REQ-028 SHALL ignore load while ready=0, with no side effects.
REQ-029 SHALL, on en=0 while in PEND, apply the shadow on the IDLE entry edge and raise ready.
REQ-030 SHALL produce glitch-free output periods: no period is truncated or shortened by a load.
REQ-031 SHALL hold ready=1 in IDLE and RUN, and ready=0 only in PEND.

Reset
REQ-032 SHALL, on reset low, immediately set state=IDLE, count=0, div_q=DEFAULT_DIV, mode=PULSE and shadow cleared.
REQ-033 SHALL, under reset, hold outputs y=0, tick=0, ready=1, count=0.
REQ-034 SHALL discard any pending load if reset is asserted mid-operation.
REQ-035 SHALL, after reset release with en=1, start RUN on the first clock edge.

Structure
REQ-036 SHALL place divn_state_t (IDLE, RUN, PEND) and divn_mode_t (PULSE, SQUARE) in shared package divn_pkg.
REQ-037 SHALL be a single flat module with no sub-module; the state register, counter and shadow are written in always_ff and next-state/output logic in always_comb.
REQ-038 SHALL contain no latches, derived clocks or gated clocks.

Verification
REQ-039 SHALL cover: reset release, en=1, defaults -> y pulses once every 3 cycles, count sequence 0,1,2,0.
REQ-040 SHALL cover: in IDLE, load div_in=4, mode_in=SQUARE, then en=1 -> y pattern 1,1,0,0 repeating, tick every 4th cycle.
REQ-041 SHALL cover: running N=5 PULSE, load N=2 at count=1 -> ready=0 until the wrap; the current 5-cycle period completes, then the period is 2; ready=1 after the wrap.
REQ-042 SHALL cover: load asserted on the wrap cycle (count=N-1) -> new divisor takes effect immediately with no PEND; a second load while ready=0 has no effect.
REQ-043 SHALL cover: div_in=0 and div_in=1 -> y=1 every RUN cycle in PULSE mode; SQUARE mode gives y constantly 1.
REQ-044 SHALL cover: reset asserted in PEND, mid-period, asynchronously -> y=0, count=0, ready=1 immediately; after release the divisor is 3.
